tick_timer_arbiter: RTL and testbench
=====================================

# tick_timer_arbiter

Shared delay timer for the calculator's timebase. Several requesters (key debounce, display blink, result hold, etc.) each need an N-tick delay. Instead of each building its own divider chain, they share one prescaler and one down-counter through this block. The block arbitrates requests round-robin, loads the granted requester's delay, counts prescaled ticks and pulses that requester's `done` when the delay expires.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `CNT_W`, 10, width of each delay field, in ticks
- `PRESCALE`, 50000, clock cycles per tick (50 MHz to 1 kHz); must be ≥2
- `PS_W`, 16, prescaler width; must hold PRESCALE-1
- `clock`  in  1  system clock, 50 MHz
- `reset`  in  1  synchronous, active-high; clears all state on the next rising edge
- `req`  in  NREQ  per-requester request level; held high until `done`, or dropped to cancel
- `delay`  in  NREQ*CNT_W  packed delays; requester i uses bits [i*CNT_W +: CNT_W], sampled only at grant
- `grant`  out  NREQ  one-hot owner of the timer; all-zero when idle
- `done`  out  NREQ  one-hot, one-cycle pulse on delay expiry
- `busy`  out  1  high whenever the FSM is not IDLE
- `remaining`  out  CNT_W  current down-counter value

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**:
  - if `req` is nonzero, select the winner round-robin: search indices ptr+1, ptr+2, … mod NREQ; the first asserted index wins.
  - Latch the winner index, set ptr to it, and load the counter with `delay[winner]`.
  - Clear the prescaler.
  - If the loaded delay is 0, go to DONE; otherwise go to RUN.
- **RUN**:
  - Prescaler counts 0..PRESCALE-1 and wraps; `tick` fires in the cycle the prescaler equals PRESCALE-1.
  - On `tick`, the counter decrements by 1.
  - If the counter is 1 on a `tick`, the counter goes to 0 and the FSM goes to DONE.
  - If `req[owner]` is low in any RUN cycle, cancel: go to IDLE, counter to 0, no `done`. Cancel takes priority over a same-cycle terminal tick.
- **DONE**: single cycle; then go to IDLE unconditionally.
- **Outputs**, all registered and derived from state:
  - `grant` = onehot(owner) in RUN and DONE, else 0.
  - `done` = onehot(owner) in DONE only.
  - `busy` = (state != IDLE).
  - `remaining` = counter value.
- **Fairness**: ptr resets to NREQ-1, so req0 has first priority after reset. A requester that is just served ranks lowest in the next arbitration.
- A requester holding `req` high after its `done` is re-arbitrated like any other and may be granted again.
- `delay` changes after grant have no effect on the running delay. `req` changes of non-owners during RUN/DONE are ignored until IDLE.
- **Arithmetic**: the counter only decrements while nonzero in RUN, so it never wraps. The prescaler wraps modulo PRESCALE.
- **Reset** (at any time, including mid-RUN):
  - state IDLE, ptr NREQ-1, counter 0, prescaler 0.
  - `grant`=0, `done`=0, `busy`=0, `remaining`=0.
  - No `done` is emitted for an aborted delay.

## Timing
- Request sampled in IDLE at edge n: from cycle n+1, `grant` and `busy` are high and `remaining`=D.
- D≥1: `done` is high exactly in cycle n+1+D*PRESCALE. `grant` holds through that cycle, and IDLE follows at n+2+D*PRESCALE.
- D=0: `grant` and `done` are both high in cycle n+1; IDLE at n+2.
- At least one IDLE cycle separates consecutive grants. The next grant is visible no earlier than 2 cycles after the `done` cycle.
- Cancel: `req[owner]` low in cycle m of RUN gives `grant`=0 and `busy`=0 from cycle m+1.
- Ticks are counted relative to the grant, not a free-running phase, so delays are exact multiples of PRESCALE.

## Test plan
Bench uses PRESCALE=4, NREQ=4, CNT_W=10.
- **Single request**: req0=1, delay0=3 in IDLE at cycle 10 → `grant`=0001 from cycle 11; `remaining` steps 3,2,1; `done`=0001 only at cycle 23; `busy` low at 24.
- **Zero delay**: req2=1, delay2=0 → `grant`=0100 and `done`=0100 together one cycle after sampling; `remaining`=0 throughout.
- **Round-robin**: req=1111 held, all delays=1 → grants in order 0,1,2,3,0; each `done` 4 cycles after its grant; 2-cycle gap between a `done` and the next grant.
- **Cancel**: req1 granted with delay 5; drop req1 after 7 cycles → `grant`=0 and `busy`=0 next cycle; no `done` pulse; a pending req3 is granted on the following arbitration.
- **Reset mid-run**: reset asserted while `remaining`=2 → next cycle all outputs 0; after release, req0 (highest priority) wins over req2 when both are asserted.
- **Max delay**: delay=1023 → `done` exactly 4092 cycles after grant; `remaining` never wraps past 0.

Source files
------------

// File: rtl/tick_timer_arbiter_if.sv
// Bundle between the requesters and the shared tick timer.
//   req       : per-requester request level (held until done, drop to cancel)
//   delay     : packed per-requester delays in ticks, slice i = [i*CNT_W +: CNT_W]
//   grant     : one-hot current owner of the timer, zero when idle
//   done      : one-hot single-cycle pulse on expiry of the owner's delay
//   busy      : timer is not idle
//   remaining : current down-counter value
interface tick_timer_arbiter_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned CNT_W = 10
);
  logic [NREQ-1:0]       req;
  logic [NREQ*CNT_W-1:0] delay;
  logic [NREQ-1:0]       grant;
  logic [NREQ-1:0]       done;
  logic                  busy;
  logic [CNT_W-1:0]      remaining;

  // Requester side.
  modport master (
    output req, delay,
    input  grant, done, busy, remaining
  );

  // Timer side.
  modport slave (
    input  req, delay,
    output grant, done, busy, remaining
  );
endinterface

// File: rtl/tick_timer_arbiter.sv
// Shared delay timer: round-robin arbitration among NREQ requesters, one
// prescaler and one down-counter; pulses the owner's done on expiry.
// Ports:
//   clock : system clock
//   reset : synchronous active-high reset
//   bus   : slave side of tick_timer_arbiter_if (req/delay in,
//           grant/done/busy/remaining out, all outputs registered)
module tick_timer_arbiter #(
  parameter int unsigned NREQ     = 4,
  parameter int unsigned CNT_W    = 10,
  parameter int unsigned PRESCALE = 50000,
  parameter int unsigned PS_W     = 16
) (
  input logic                 clock,
  input logic                 reset,
  tick_timer_arbiter_if.slave bus
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PS_W-1:0]  ps_q, ps_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [NREQ-1:0]  done_q, done_d;
  logic             busy_q, busy_d;

  logic [IDX_W-1:0] win;
  logic [IDX_W-1:0] cand;
  logic             win_found;
  logic [CNT_W-1:0] win_delay;
  logic             tick;
  logic             owner_req;

  // Round-robin search starting just after the last served index.
  always_comb begin
    win       = ptr_q;
    win_found = 1'b0;
    cand      = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IDX_W'((32'(ptr_q) + k) % NREQ);
      if (!win_found && bus.req[cand]) begin
        win       = cand;
        win_found = 1'b1;
      end
    end
  end

  assign win_delay = bus.delay[32'(win)*CNT_W +: CNT_W];
  assign tick      = (state_q == S_RUN) && (ps_q == PS_W'(PRESCALE - 1));
  assign owner_req = bus.req[ptr_q];

  // Next-state and next-output logic; ptr doubles as the owner index.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    ps_d    = ps_q;

    case (state_q)
      S_IDLE: begin
        // Prescaler restarts at each grant so delays are exact multiples.
        ps_d = '0;
        if (win_found) begin
          ptr_d   = win;
          cnt_d   = win_delay;
          state_d = (win_delay == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (!owner_req) begin
          // Cancel wins over a terminal tick in the same cycle.
          state_d = S_IDLE;
          cnt_d   = '0;
          ps_d    = '0;
        end else begin
          ps_d = tick ? '0 : ps_q + PS_W'(1);
          if (tick && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              state_d = S_DONE;
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        ps_d    = '0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d  = (state_d != S_IDLE);
    grant_d = busy_d ? (NREQ'(1) << ptr_d) : '0;
    done_d  = (state_d == S_DONE) ? (NREQ'(1) << ptr_d) : '0;
  end

  // State and output registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      ptr_q   <= IDX_W'(NREQ - 1);
      cnt_q   <= '0;
      ps_q    <= '0;
      grant_q <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      ps_q    <= ps_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.grant     = grant_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;
  assign bus.remaining = cnt_q;

endmodule

// File: tb/tb_tick_timer_arbiter.sv
// Directed bench for tick_timer_arbiter with PRESCALE=4, NREQ=4, CNT_W=10.
module tb_tick_timer_arbiter;

  localparam int unsigned NREQ     = 4;
  localparam int unsigned CNT_W    = 10;
  localparam int unsigned PRESCALE = 4;
  localparam int unsigned PS_W     = 16;

  logic clock;
  logic reset;

  tick_timer_arbiter_if #(.NREQ(NREQ), .CNT_W(CNT_W)) bus_if ();

  tick_timer_arbiter #(
    .NREQ    (NREQ),
    .CNT_W   (CNT_W),
    .PRESCALE(PRESCALE),
    .PS_W    (PS_W)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus_if)
  );

  int n_cmp;
  int n_err;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Compare one observed value against its expected value.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(posedge clock);
    #1;
  endtask

  task automatic set_delay(input int idx, input logic [CNT_W-1:0] d);
    bus_if.delay[idx*CNT_W +: CNT_W] = d;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [3:0] rr_order [5];
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    bus_if.req   = '0;
    bus_if.delay = '0;
    step(2);
    reset = 1'b0;
    step(1);

    // Reset state.
    check("rst_grant", 32'(bus_if.grant), 32'h0);
    check("rst_done", 32'(bus_if.done), 32'h0);
    check("rst_busy", 32'(bus_if.busy), 32'h0);
    check("rst_rem", 32'(bus_if.remaining), 32'h0);

    // Single request, delay 3: done 12 cycles after grant.
    set_delay(0, 10'd3);
    bus_if.req = 4'b0001;
    step(1);
    check("s_grant", 32'(bus_if.grant), 32'h1);
    check("s_busy", 32'(bus_if.busy), 32'h1);
    check("s_rem3", 32'(bus_if.remaining), 32'd3);
    set_delay(0, 10'd7);  // post-grant change must not matter
    step(4);
    check("s_rem2", 32'(bus_if.remaining), 32'd2);
    step(4);
    check("s_rem1", 32'(bus_if.remaining), 32'd1);
    step(3);
    check("s_nodone", 32'(bus_if.done), 32'h0);
    step(1);
    check("s_done", 32'(bus_if.done), 32'h1);
    check("s_done_grant", 32'(bus_if.grant), 32'h1);
    check("s_done_rem", 32'(bus_if.remaining), 32'h0);
    bus_if.req = 4'b0000;
    step(1);
    check("s_idle_busy", 32'(bus_if.busy), 32'h0);
    check("s_idle_done", 32'(bus_if.done), 32'h0);

    // Zero delay: grant and done together.
    set_delay(2, 10'd0);
    bus_if.req = 4'b0100;
    step(1);
    check("z_grant", 32'(bus_if.grant), 32'h4);
    check("z_done", 32'(bus_if.done), 32'h4);
    check("z_rem", 32'(bus_if.remaining), 32'h0);
    bus_if.req = 4'b0000;
    step(1);
    check("z_idle", 32'(bus_if.busy), 32'h0);

    // Round-robin from a fresh reset.
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    for (int i = 0; i < NREQ; i++) set_delay(i, 10'd1);
    rr_order[0] = 4'b0001;
    rr_order[1] = 4'b0010;
    rr_order[2] = 4'b0100;
    rr_order[3] = 4'b1000;
    rr_order[4] = 4'b0001;
    bus_if.req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check($sformatf("rr%0d_grant", i), 32'(bus_if.grant), 32'(rr_order[i]));
      step(3);
      check($sformatf("rr%0d_nodone", i), 32'(bus_if.done), 32'h0);
      step(1);
      check($sformatf("rr%0d_done", i), 32'(bus_if.done), 32'(rr_order[i]));
      if (i == 4) bus_if.req = 4'b0000;
      step(1);
      check($sformatf("rr%0d_gap", i), 32'(bus_if.grant), 32'h0);
    end

    // Cancel: owner 1 drops req, pending req3 is served next.
    set_delay(1, 10'd5);
    set_delay(3, 10'd2);
    bus_if.req = 4'b1010;
    step(1);
    check("c_grant", 32'(bus_if.grant), 32'h2);
    check("c_rem5", 32'(bus_if.remaining), 32'd5);
    step(6);
    check("c_rem4", 32'(bus_if.remaining), 32'd4);
    bus_if.req = 4'b1000;
    step(1);
    check("c_grant0", 32'(bus_if.grant), 32'h0);
    check("c_busy0", 32'(bus_if.busy), 32'h0);
    check("c_nodone", 32'(bus_if.done), 32'h0);
    check("c_rem0", 32'(bus_if.remaining), 32'h0);
    step(1);
    check("c_next", 32'(bus_if.grant), 32'h8);
    bus_if.req = 4'b0000;
    step(1);
    check("c_next_cancel", 32'(bus_if.busy), 32'h0);

    // Reset mid-run, then req0 beats req2.
    set_delay(0, 10'd3);
    bus_if.req = 4'b0001;
    step(1);
    check("r_grant", 32'(bus_if.grant), 32'h1);
    step(4);
    check("r_rem2", 32'(bus_if.remaining), 32'd2);
    reset = 1'b1;
    step(1);
    check("r_grant0", 32'(bus_if.grant), 32'h0);
    check("r_done0", 32'(bus_if.done), 32'h0);
    check("r_busy0", 32'(bus_if.busy), 32'h0);
    check("r_rem0", 32'(bus_if.remaining), 32'h0);
    reset = 1'b0;
    set_delay(2, 10'd4);
    bus_if.req = 4'b0101;
    step(1);
    check("r_prio", 32'(bus_if.grant), 32'h1);
    bus_if.req = 4'b0000;
    step(1);
    check("r_cancel", 32'(bus_if.busy), 32'h0);

    // Max delay: done exactly 4092 cycles after grant.
    set_delay(0, 10'd1023);
    bus_if.req = 4'b0001;
    step(1);
    check("m_grant", 32'(bus_if.grant), 32'h1);
    check("m_rem", 32'(bus_if.remaining), 32'd1023);
    step(2048);
    check("m_mid_rem", 32'(bus_if.remaining), 32'd511);
    step(4091 - 2048);
    check("m_rem1", 32'(bus_if.remaining), 32'd1);
    check("m_nodone", 32'(bus_if.done), 32'h0);
    step(1);
    check("m_done", 32'(bus_if.done), 32'h1);
    check("m_rem0", 32'(bus_if.remaining), 32'h0);
    bus_if.req = 4'b0000;
    step(1);
    check("m_idle_rem", 32'(bus_if.remaining), 32'h0);
    check("m_idle_busy", 32'(bus_if.busy), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
